gem_kchar_gen: RTL

//  Four-fiber GEM K-character stream generator: transmit side of the per-fiber kchar sync comparison.

---
 rtl/gem_kchar_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/gem_kchar_gen.sv
// Four-fiber GEM K-character generator: orbit-framed K28.x stream with per-fiber
// skew taps and single-cycle error injection.
module gem_kchar_gen #(
  parameter int unsigned ORBIT_LEN   = 3564,
  parameter int unsigned RESYNC_HOLD = 16,
  parameter int unsigned MAXDLY      = 3
) (
  input  logic        clock,
  input  logic        global_reset,
  input  logic        ttc_resync,
  input  logic        enable,
  input  logic [7:0]  fiber_dly,
  input  logic        inject_err,
  input  logic [1:0]  inject_fiber,
  output logic [7:0]  gem0_kchar,
  output logic [7:0]  gem1_kchar,
  output logic [7:0]  gem2_kchar,
  output logic [7:0]  gem3_kchar,
  output logic        bc0_out,
  output logic        running,
  output logic [11:0] frame_cnt
);

  localparam logic [7:0] SYM_IDLE = 8'hBC;
  localparam logic [7:0] SYM_BC0  = 8'h1C;
  localparam logic [7:0] SYM_RSY  = 8'h3C;
  localparam logic [7:0] SYM_ERR  = 8'hF7;

  localparam int unsigned HW         = (RESYNC_HOLD > 1) ? $clog2(RESYNC_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESYNC_HOLD - 1);
  localparam logic [11:0]  FRAME_LAST = 12'(ORBIT_LEN - 1);
  localparam logic [1:0]   MAXD       = 2'(MAXDLY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESYNC,
    ST_RUN
  } state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [11:0]    frame_q, frame_d;
  logic [7:0]     sym_base_q, sym_base_d;
  logic           bc0_q;
  logic           running_q;
  logic [3:1][7:0] tap_q;
  logic [3:0][7:0] taps;
  logic [3:0][7:0] gem_q, gem_d;

  // Skew fields above MAXDLY are clamped to the deepest tap.
  function automatic logic [7:0] fiber_sym(input logic [1:0] dly, input logic hit,
                                           input logic [3:0][7:0] t);
    logic [1:0] d;
    d = (dly > MAXD) ? MAXD : dly;
    return hit ? SYM_ERR : t[d];
  endfunction

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    if (!enable) begin
      state_d = ST_IDLE;
      hold_d  = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RESYNC;
          hold_d  = '0;
          frame_d = '0;
        end
        ST_RESYNC: begin
          if (ttc_resync) begin
            hold_d  = '0;
            frame_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
            hold_d  = '0;
            frame_d = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_RUN: begin
          if (ttc_resync) begin
            state_d = ST_RESYNC;
            hold_d  = '0;
            frame_d = '0;
          end else begin
            frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 12'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
          frame_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_RESYNC: sym_base_d = SYM_RSY;
      ST_RUN:    sym_base_d = (frame_q == '0) ? SYM_BC0 : SYM_IDLE;
      default:   sym_base_d = SYM_IDLE;
    endcase
  end

  always_comb begin
    taps[0]   = sym_base_q;
    taps[3:1] = tap_q;
    gem_d[0]  = fiber_sym(fiber_dly[1:0], inject_err && (inject_fiber == 2'd0), taps);
    gem_d[1]  = fiber_sym(fiber_dly[3:2], inject_err && (inject_fiber == 2'd1), taps);
    gem_d[2]  = fiber_sym(fiber_dly[5:4], inject_err && (inject_fiber == 2'd2), taps);
    gem_d[3]  = fiber_sym(fiber_dly[7:6], inject_err && (inject_fiber == 2'd3), taps);
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      frame_q    <= '0;
      sym_base_q <= SYM_IDLE;
      bc0_q      <= 1'b0;
      running_q  <= 1'b0;
      tap_q      <= {3{SYM_IDLE}};
      gem_q      <= {4{SYM_IDLE}};
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      frame_q    <= frame_d;
      sym_base_q <= sym_base_d;
      bc0_q      <= (sym_base_d == SYM_BC0);
      // running tracks the state register itself, so it is built from state_d
      running_q  <= (state_d == ST_RUN);
      tap_q      <= {tap_q[2:1], sym_base_q};
      gem_q      <= gem_d;
    end
  end

  assign gem0_kchar = gem_q[0];
  assign gem1_kchar = gem_q[1];
  assign gem2_kchar = gem_q[2];
  assign gem3_kchar = gem_q[3];
  assign bc0_out    = bc0_q;
  assign running    = running_q;
  assign frame_cnt  = frame_q;

endmodule
